branch_hazard_ctrl: RTL

//  Sequences operand hazards for blt/bne in decode. Compares branch rd/rs against in-flight

---
 rtl/branch_hazard_ctrl_pkg.sv | 38 +++
 rtl/branch_hazard_ctrl_hazard_match.sv | 48 ++++
 rtl/branch_hazard_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants for the branch hazard controller: opcodes, special
// destination registers, forwarding select encodings and FSM states.
package branch_hazard_ctrl_pkg;

  // Opcodes that write a destination register
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  // Branch opcodes resolved by the decode-stage comparator
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;

  // Implicit destinations
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [4:0] REG_RA      = 5'd31;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  // Forwarding select encodings
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_X   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MD_WAIT   = 2'd2,
    ST_FLUSH     = 2'd3
  } state_t;

  // True for the two branch opcodes this block protects
  function automatic logic is_branch(input logic [4:0] opcode);
    return (opcode == OP_BNE) || (opcode == OP_BLT);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_hazard_match.sv
// Decodes whether one pipeline stage holds a register writer and compares
// its effective destination against the two branch source registers.
module hazard_match
  import branch_hazard_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] opcode,
  input  logic [4:0] dest_field,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  output logic       match_a,
  output logic       match_b
);

  logic       writer;
  logic [4:0] dest;
  logic       live;

  // Writer decode: jal and setx write fixed registers, others use the rd field
  always_comb begin
    writer = 1'b0;
    dest   = dest_field;
    case (opcode)
      OP_ALU, OP_ADDI, OP_LW: begin
        writer = 1'b1;
        dest   = dest_field;
      end
      OP_JAL: begin
        writer = 1'b1;
        dest   = REG_RA;
      end
      OP_SETX: begin
        writer = 1'b1;
        dest   = REG_RSTATUS;
      end
      default: begin
        writer = 1'b0;
        dest   = dest_field;
      end
    endcase
  end

  // r0 is never a real producer, so a zero destination cannot match
  assign live    = valid & writer & (dest != REG_ZERO);
  assign match_a = live & (src_a == dest);
  assign match_b = live & (src_b == dest);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch operand hazard controller: forwards X/M results to the decode-stage
// branch comparator, stalls decode on load-use and multdiv hazards, and
// flushes wrong-path instructions after a taken branch.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int MD_TIMEOUT   = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_opcode,
  input  logic [4:0]       d_rd,
  input  logic [4:0]       d_rs,
  input  logic             x_valid,
  input  logic [4:0]       x_opcode,
  input  logic [4:0]       x_rd,
  input  logic             m_valid,
  input  logic [4:0]       m_opcode,
  input  logic [4:0]       m_rd,
  input  logic             md_busy,
  input  logic [4:0]       md_rd,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_rd,
  output logic [1:0]       fwd_rs,
  output logic [CNT_W-1:0] hazard_cnt
);

  localparam int         MD_W       = $clog2(MD_TIMEOUT + 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

  state_t          state, state_next;
  logic            stall_next, flush_next;
  logic [1:0]      flush_cnt, flush_cnt_next;
  logic [MD_W-1:0] md_timer, md_timer_next;

  logic x_match_rd, x_match_rs;
  logic m_match_rd, m_match_rs;
  logic br_hit, load_hit, md_hit;

  hazard_match u_x_match (
    .valid      (x_valid),
    .opcode     (x_opcode),
    .dest_field (x_rd),
    .src_a      (d_rd),
    .src_b      (d_rs),
    .match_a    (x_match_rd),
    .match_b    (x_match_rs)
  );

  hazard_match u_m_match (
    .valid      (m_valid),
    .opcode     (m_opcode),
    .dest_field (m_rd),
    .src_a      (d_rd),
    .src_b      (d_rs),
    .match_a    (m_match_rd),
    .match_b    (m_match_rs)
  );

  assign br_hit   = d_valid & is_branch(d_opcode);
  // A load in X has no data yet; wait one cycle and pick it up from M
  assign load_hit = br_hit & (x_opcode == OP_LW) & (x_match_rd | x_match_rs);
  assign md_hit   = br_hit & md_busy & (md_rd != REG_ZERO) &
                    ((d_rd == md_rd) | (d_rs == md_rd));

  // Next-state and registered-output decode; a taken branch overrides all stalls
  always_comb begin
    state_next     = state;
    stall_next     = 1'b0;
    flush_next     = 1'b0;
    flush_cnt_next = flush_cnt;
    md_timer_next  = md_timer;
    if (br_taken) begin
      state_next     = ST_FLUSH;
      flush_next     = 1'b1;
      flush_cnt_next = FLUSH_LOAD;
    end else begin
      case (state)
        ST_RUN: begin
          if (md_hit) begin
            state_next    = ST_MD_WAIT;
            stall_next    = 1'b1;
            md_timer_next = '0;
          end else if (load_hit) begin
            state_next = ST_LOAD_WAIT;
            stall_next = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_LOAD_WAIT: begin
          state_next = ST_RUN;
        end
        ST_MD_WAIT: begin
          if (!md_busy) begin
            state_next = ST_RUN;
          end else if (md_timer == MD_LAST) begin
            state_next = ST_RUN;
          end else begin
            md_timer_next = md_timer + MD_W'(1);
            stall_next    = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 2'd0) begin
            state_next = ST_RUN;
          end else begin
            flush_cnt_next = flush_cnt - 2'd1;
            flush_next     = 1'b1;
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // State, registered stall/flush and sequencing counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_RUN;
      stall     <= 1'b0;
      flush     <= 1'b0;
      flush_cnt <= 2'd0;
      md_timer  <= '0;
    end else begin
      state     <= state_next;
      stall     <= stall_next;
      flush     <= flush_next;
      flush_cnt <= flush_cnt_next;
      md_timer  <= md_timer_next;
    end
  end

  // Saturating count of cycles spent with decode stalled
  always_ff @(posedge clock) begin
    if (!reset) begin
      hazard_cnt <= '0;
    end else if (stall && (hazard_cnt != {CNT_W{1'b1}})) begin
      hazard_cnt <= hazard_cnt + CNT_W'(1);
    end else begin
      hazard_cnt <= hazard_cnt;
    end
  end

  // Forwarding priority: youngest producer (X) first, then M, else regfile
  always_comb begin
    fwd_rd = FWD_REG;
    fwd_rs = FWD_REG;
    if ((state == ST_RUN) && br_hit) begin
      if (x_match_rd) begin
        fwd_rd = FWD_X;
      end else if (m_match_rd) begin
        fwd_rd = FWD_M;
      end else begin
        fwd_rd = FWD_REG;
      end
      if (x_match_rs) begin
        fwd_rs = FWD_X;
      end else if (m_match_rs) begin
        fwd_rs = FWD_M;
      end else begin
        fwd_rs = FWD_REG;
      end
    end else begin
      fwd_rd = FWD_REG;
      fwd_rs = FWD_REG;
    end
  end

endmodule
